// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction address width, halt encoding and
// the fetch RUN/HALT state type used by fetch, hazard and branch units.
package pipeline_pkg;

    localparam int          ADDR_W   = 10;
    localparam logic [31:0] HLT_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/unidad_fetch_if.sv
// Fetch-unit bus: hazard/branch controls in, instruction memory port and
// fetched instruction out. The fetch unit takes the master side.
interface unidad_fetch_if #(
    parameter int ADDR_W = pipeline_pkg::ADDR_W
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] direccion;
    logic [31:0]       instruccion_mem;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_next_out;
    logic              valid_out;
    logic              halted;

    modport master (
        input  stall, redirect, redirect_target, instruccion_mem,
        output direccion, instr_out, pc_next_out, valid_out, halted
    );

    modport slave (
        output stall, redirect, redirect_target, instruccion_mem,
        input  direccion, instr_out, pc_next_out, valid_out, halted
    );
endinterface

// File: rtl/registro_pc.sv
// Program-counter register set: next address to issue, address whose data is
// on the memory bus, and whether that data is a live fetch.
module registro_pc #(
    parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic              clear_valid,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_fetched,
    output logic              valid_fetch
);

    // Priority load > clear_valid > advance; with none asserted everything holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            pc_fetched  <= '0;
            valid_fetch <= 1'b0;
        end else if (load) begin
            pc          <= target + ADDR_W'(1);
            pc_fetched  <= target;
            valid_fetch <= 1'b1;
        end else if (clear_valid) begin
            valid_fetch <= 1'b0;
        end else if (advance) begin
            pc          <= pc + ADDR_W'(1);
            pc_fetched  <= pc;
            valid_fetch <= 1'b1;
        end
    end

endmodule

// File: rtl/unidad_fetch.sv
// Instruction fetch unit: drives the synchronous instruction memory address,
// presents the fetched word and stops permanently on the halt encoding.
//
//   state | meaning
//   RUN   | fetching; stall holds, redirect reloads, HLT_WORD moves to HALT
//   HALT  | frozen on the halt word; only reset leaves
module unidad_fetch #(
    parameter int          ADDR_W   = pipeline_pkg::ADDR_W,
    parameter logic [31:0] HLT_WORD = pipeline_pkg::HLT_WORD
) (
    input  logic             clk,
    input  logic             reset,
    unidad_fetch_if.master   bus
);

    pipeline_pkg::fetch_state_t state, state_next;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_fetched;
    logic              valid_fetch;
    logic              load;
    logic              advance;
    logic              clear_valid;
    logic              running;
    logic              halt_detect;

    registro_pc #(.ADDR_W(ADDR_W)) u_registro_pc (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .clear_valid (clear_valid),
        .target      (bus.redirect_target),
        .pc          (pc),
        .pc_fetched  (pc_fetched),
        .valid_fetch (valid_fetch)
    );

    assign running     = (state == pipeline_pkg::RUN);
    assign halt_detect = bus.valid_out && (bus.instruccion_mem == HLT_WORD);

    // Redirect is only honoured in RUN so a halted unit keeps re-reading the halt word.
    assign bus.direccion   = (bus.redirect && running)   ? bus.redirect_target :
                             (bus.stall || !running)     ? pc_fetched : pc;
    assign bus.valid_out   = valid_fetch && !bus.redirect && running;
    assign bus.instr_out   = bus.instruccion_mem;
    assign bus.pc_next_out = pc_fetched + ADDR_W'(1);
    assign bus.halted      = !running;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= pipeline_pkg::RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        advance     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            pipeline_pkg::RUN: begin
                if (bus.redirect) begin
                    load = 1'b1;
                end else if (bus.stall) begin
                    // hold: memory re-reads pc_fetched
                end else if (halt_detect) begin
                    clear_valid = 1'b1;
                    state_next  = pipeline_pkg::HALT;
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_next = pipeline_pkg::HALT;
            end
        endcase
    end

endmodule

// File: doc/unidad_fetch.md
UNIDAD_FETCH -- requirements
Module: unidad_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, the instruction word-address width.
REQ-002 The block SHALL have parameter HLT_WORD, default 32'h00000000, the halt encoding.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port stall, input, 1 bit: hold request from the hazard unit.
REQ-006 Port redirect, input, 1 bit: taken branch or jump, squashing the presented word.
REQ-007 Port redirect_target, input, ADDR_W bits: word address of the new fetch.
REQ-008 Port direccion, output, ADDR_W bits: read address driven to the synchronous instruction memory.
REQ-009 Port instruccion_mem, input, 32 bits: memory data, valid one cycle after direccion is sampled.
REQ-010 Port instr_out, output, 32 bits: fetched instruction, equal to instruccion_mem.
REQ-011 Port pc_next_out, output, ADDR_W bits: word address following instr_out.
REQ-012 Port valid_out, output, 1 bit: instr_out is a live instruction.
REQ-013 Port halted, output, 1 bit: the fetch unit has stopped on HLT_WORD.

Function
REQ-014 The block SHALL hold these registers: pc (next address to issue), pc_fetched (address whose data is on instruccion_mem), valid_fetch, and state in {RUN, HALT}.
REQ-015 direccion SHALL be combinational: redirect ? redirect_target : (stall or state==HALT) ? pc_fetched : pc.
REQ-016 valid_out SHALL equal valid_fetch AND NOT redirect AND state==RUN.
REQ-017 pc_next_out SHALL equal pc_fetched+1, truncated to ADDR_W bits.
REQ-018 RUN with no stall and no redirect: pc<=pc+1; pc_fetched<=pc; valid_fetch<=1.
REQ-019 RUN with stall and no redirect: pc, pc_fetched and valid_fetch SHALL hold. Memory re-reads pc_fetched, so instr_out is stable on the next cycle.
REQ-020 Redirect SHALL take priority over stall and halt detection: pc<=redirect_target+1; pc_fetched<=redirect_target; valid_fetch<=1.
REQ-021 The redirect penalty SHALL be the squashed word only; the target instruction SHALL be presented with valid_out=1 on the cycle after redirect.
REQ-022 HALT detection: valid_out=1 with instr_out==HLT_WORD and stall=0 SHALL move state RUN->HALT and clear valid_fetch at the edge.
REQ-023 With stall=1, a presented HLT_WORD SHALL be detected only once the stall drops.
REQ-024 HALT SHALL keep pc and pc_fetched, keep valid_out=0, drive halted=1, and ignore stall and redirect; only reset SHALL exit HALT.
REQ-025 PC arithmetic SHALL be modulo 2^ADDR_W: 1023+1 wraps to 0, both for pc and for pc_next_out.
REQ-026 Latency: an address issued at edge N SHALL appear on instr_out with valid_out=1 during the cycle after edge N.

Reset
REQ-027 While reset=1, the block SHALL force pc=0, pc_fetched=0, valid_fetch=0 and state=RUN, giving direccion=0, valid_out=0, halted=0 and pc_next_out=1.
REQ-028 At the first edge after reset release, memory SHALL read address 0, and valid_out SHALL rise in the following cycle.
REQ-029 Reset asserted mid-stall, mid-redirect or in HALT SHALL take effect immediately and asynchronously, discarding all fetch state.

Structure
REQ-030 ADDR_W, HLT_WORD and the RUN/HALT state encoding SHALL live in shared package pipeline_pkg, used also by the hazard and branch units.
REQ-031 The PC/pc_fetched/valid register set SHALL be one natural sub-module, registro_pc; the direccion mux and halt FSM SHALL stay in unidad_fetch.

Verification
REQ-032 Reset then free-run with memory [0]=20420020, [1]=20630001, [2]=00432006, [3]=0 -> instr_out sequence 20420020, 20630001, 00432006 with pc_next_out 1, 2, 3.
REQ-033 Same program, HLT at word 3 -> halted=1 from the following cycle, valid_out=0, and direccion frozen at 3.
REQ-034 stall=1 for 2 cycles while 20630001 is presented -> direccion=1, and instr_out stays 20630001 with valid_out=1 for 3 cycles, then 00432006.
REQ-035 redirect=1 with target 0 while 20630001 is presented -> valid_out=0 that cycle, then 20420020 valid with pc_next_out=1.
REQ-036 Simultaneous stall=1 and redirect=1 with target 2 -> redirect wins; the next valid instr_out is 00432006.
REQ-037 redirect to 1023 with memory [1023]=20420020 -> pc_next_out=0, then the next fetch is address 0; reset pulsed in HALT -> valid_out=0 and direccion=0 immediately.
